sine_nco: RTL and testbench

//  Numerically controlled oscillator: the phase generator that drives sine_table.

---
 rtl/sine_nco.sv | 92 +++++++++
 tb/tb_sine_nco.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_nco.sv
// Numerically controlled oscillator: a phase accumulator forms the sine_table id and
// registers the table answer into a valid/ready sample stream.
module sine_nco #(
  parameter int ROM_DEPTH = 64,
  parameter int ROM_WIDTH = 8,
  parameter int ADDRW     = $clog2(4*ROM_DEPTH),
  parameter int PHASEW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASEW-1:0]      freq_in,
  input  logic                   freq_load,
  input  logic [ADDRW-1:0]       phase_off,
  output logic [ADDRW-1:0]       id,
  input  logic [2*ROM_WIDTH-1:0] tab_data,
  output logic [2*ROM_WIDTH-1:0] sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   wrap,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [PHASEW-1:0] acc, acc_sum, freq_act, freq_pend;
  logic              pend_flag;
  logic              carry, adv, xfer, acc_clr;

  assign id               = acc[PHASEW-1 -: ADDRW] + phase_off;
  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, freq_act};
  assign adv              = (state == RUN) && !stop && (!sample_valid || sample_ready);
  assign xfer             = sample_valid && sample_ready;
  assign busy             = (state != IDLE);

  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    unique case (state)
      IDLE:  if (start && !stop) state_nxt = RUN;
      RUN:   if (stop) state_nxt = DRAIN;
      DRAIN: if (!sample_valid || xfer) begin
        state_nxt = IDLE;
        acc_clr   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      freq_act     <= '0;
      freq_pend    <= '0;
      pend_flag    <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      state <= state_nxt;
      wrap  <= adv && carry;

      if (adv) begin
        sample       <= tab_data;
        sample_valid <= 1'b1;
        acc          <= acc_sum;
      end else begin
        if (xfer)    sample_valid <= 1'b0;
        if (acc_clr) acc          <= '0;
      end

      // While running, a new tuning word only takes effect on a carry advance so the
      // phase stays continuous at the zero crossing; a load on that very advance wins.
      if (state == IDLE) begin
        if (freq_load) freq_act <= freq_in;
      end else if (freq_load && adv && carry) begin
        freq_act  <= freq_in;
        pend_flag <= 1'b0;
      end else if (freq_load) begin
        freq_pend <= freq_in;
        pend_flag <= 1'b1;
      end else if (adv && carry && pend_flag) begin
        freq_act  <= freq_pend;
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sine_nco.sv
// Scoreboard bench for sine_nco: stimulus pushes expected samples, a negedge monitor
// pops and compares them as the DUT presents its sample stream.
module tb_sine_nco;

  logic        clk = 1'b0;
  logic        rst, start, stop, freq_load, sample_ready;
  logic [15:0] freq_in;
  logic [7:0]  phase_off;
  logic [7:0]  id;
  logic [15:0] tab_data, sample;
  logic        sample_valid, wrap, busy;

  sine_nco #(.ROM_DEPTH(64), .ROM_WIDTH(8), .PHASEW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .freq_in(freq_in), .freq_load(freq_load), .phase_off(phase_off),
    .id(id), .tab_data(tab_data), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] s; logic w; } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  // Triangle stand-in for sine_table: 0 at id 0/128, +0x100 at 64, -0x100 at 192.
  function automatic logic [15:0] tab(input logic [7:0] a);
    int o, v;
    o = int'(a[5:0]);
    case (a[7:6])
      2'd0: v = 4*o;
      2'd1: v = 256 - 4*o;
      2'd2: v = -4*o;
      default: v = -(256 - 4*o);
    endcase
    return 16'(v);
  endfunction

  always_comb tab_data = tab(id);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  bit fresh = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (sample_valid) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_sample: got %0h expected none at %0t", sample, $time);
      end else begin
        chk("wrap", {31'd0, wrap}, {31'd0, fresh ? q[0].w : 1'b0});
        if (sample_ready) begin
          e = q.pop_front();
          chk("sample", {16'd0, sample}, {16'd0, e.s});
        end
      end
    end
    fresh = !sample_valid || sample_ready;
  end

  // Reference phase model
  logic [15:0] m_acc = '0, m_freq = '0, m_pend = '0;
  logic        m_pflag = 1'b0;
  logic [7:0]  m_poff = '0;

  task automatic madv(input bit load, input logic [15:0] val);
    logic [7:0]  mid;
    logic [16:0] sum;
    exp_t        e;
    mid = m_acc[15:8] + m_poff;
    sum = {1'b0, m_acc} + {1'b0, m_freq};
    e.s = tab(mid);
    e.w = sum[16];
    q.push_back(e);
    if (load && sum[16]) begin m_freq = val; m_pflag = 1'b0; end
    else if (load) begin m_pend = val; m_pflag = 1'b1; end
    else if (sum[16] && m_pflag) begin m_freq = m_pend; m_pflag = 1'b0; end
    m_acc = sum[15:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      madv(1'b0, 16'h0);
      step();
    end
  endtask

  task automatic idle_load(input logic [15:0] val);
    freq_in = val; freq_load = 1'b1;
    step();
    freq_load = 1'b0;
    m_freq = val;
  endtask

  task automatic ld_run(input logic [15:0] val);
    freq_in = val; freq_load = 1'b1;
    madv(1'b1, val);
    step();
    freq_load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    m_acc = '0;
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; freq_load = 1'b0;
    freq_in = '0; phase_off = '0; sample_ready = 1'b1;
    step(); step();
    chk("rst_id", {24'd0, id}, 32'd0);
    chk("rst_sample", {16'd0, sample}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();

    // 1: unit step through the whole table, wrap after 256 samples
    idle_load(16'h0100);
    do_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    run(258);
    chk("t1_id", {24'd0, id}, 32'd2);
    stop_run();

    // 2: quarter-wave step
    idle_load(16'h4000);
    do_start();
    run(9);
    chk("t2_id", {24'd0, id}, 32'd64);
    stop_run();

    // 3: backpressure with phase offset 16
    phase_off = 8'd16; m_poff = 8'd16;
    sample_ready = 1'b0;
    do_start();
    madv(1'b0, 16'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_sample", {16'd0, sample}, 32'h0040);
      chk("t3_hold_id", {24'd0, id}, 32'd80);
      chk("t3_hold_valid", {31'd0, sample_valid}, 32'd1);
      chk("t3_hold_wrap", {31'd0, wrap}, 32'd0);
    end
    sample_ready = 1'b1;
    run(6);
    stop_run();
    phase_off = '0; m_poff = '0;

    // 4a: loads mid-run wait for the wrap; last load wins
    idle_load(16'h0100);
    do_start();
    run(5);
    ld_run(16'h0300);
    run(4);
    ld_run(16'h0200);
    run(250);
    chk("t4a_id", {24'd0, id}, 32'd10);
    stop_run();

    // 4b: load on the carry advance itself
    idle_load(16'h0100);
    do_start();
    run(255);
    ld_run(16'h0200);
    run(5);
    chk("t4b_id", {24'd0, id}, 32'd10);
    stop_run();

    // 5: stop under backpressure drains, then restart at phase_off
    idle_load(16'h4000);
    do_start();
    run(3);
    sample_ready = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t5_drain_busy", {31'd0, busy}, 32'd1);
    chk("t5_drain_valid", {31'd0, sample_valid}, 32'd1);
    step(); step();
    chk("t5_hold_busy", {31'd0, busy}, 32'd1);
    phase_off = 8'd37; m_poff = 8'd37;
    sample_ready = 1'b1;
    step();
    m_acc = '0;
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    chk("t5_idle_valid", {31'd0, sample_valid}, 32'd0);
    chk("t5_idle_id", {24'd0, id}, 32'd37);
    do_start();
    run(2);
    chk("t5_run_id", {24'd0, id}, 32'd165);
    stop_run();
    phase_off = '0; m_poff = '0;

    // 6: reset mid-run with a held sample; start+stop together in IDLE
    idle_load(16'h0100);
    do_start();
    run(5);
    sample_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    q.delete();
    m_acc = '0; m_freq = '0; m_pend = '0; m_pflag = 1'b0;
    chk("t6_rst_id", {24'd0, id}, 32'd0);
    chk("t6_rst_sample", {16'd0, sample}, 32'd0);
    chk("t6_rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("t6_rst_wrap", {31'd0, wrap}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    sample_ready = 1'b1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("t6_startstop_busy", {31'd0, busy}, 32'd0);
    step();
    chk("t6_startstop_valid", {31'd0, sample_valid}, 32'd0);

    // freq_act is 0 after reset: the same phase repeats, no wrap
    do_start();
    run(3);
    chk("t6_zero_id", {24'd0, id}, 32'd0);
    stop_run();

    repeat (4) step();
    chk("queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
